// File: rtl/outer_product_scheduler_pkg.sv
// Shared types and sizes for the outer-product scheduler: FSM state encoding,
// vector/element/product widths and the derived counter widths.
package outer_product_scheduler_pkg;

    localparam int N  = 16;
    localparam int DW = 4;
    localparam int PW = 2 * DW;
    localparam int CW = $clog2(N);
    localparam int IW = $clog2(N * N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CALC = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/outer_product_scheduler_arb.sv
// Two-way round-robin pick: a lone requester wins outright, a tie goes to
// the requester named by rr_ptr. Purely combinational.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       rr_ptr,
    output logic [1:0] pick
);

    always_comb begin
        pick = req;
        if (req == 2'b11) begin
            pick = rr_ptr ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/outer_product_scheduler.sv
// Shares one NxN outer-product engine between two requesters: grants one,
// loads its A/B vectors, then streams every A[i]*B[j] into a FIFO port.
module outer_product_scheduler
    import outer_product_scheduler_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    req,
    output logic [1:0]    grant,
    input  logic [1:0]    in_valid,
    input  logic [DW-1:0] in_a0,
    input  logic [DW-1:0] in_b0,
    input  logic [DW-1:0] in_a1,
    input  logic [DW-1:0] in_b1,
    input  logic          fifo_full,
    output logic          out_valid,
    output logic [PW-1:0] out_data,
    output logic          out_id,
    output logic          out_last,
    output logic          busy,
    output logic          done,
    output state_t        dbg_state
);

    // Output handshake: a beat transfers on a rising edge where out_valid=1 and
    // fifo_full=0; while blocked, out_valid/out_data/out_last hold unchanged.

    state_t        state;
    logic          rr_ptr;
    logic [CW-1:0] cnt;
    logic [IW-1:0] k;
    logic          issued_all;
    logic [DW-1:0] a_mem [N];
    logic [DW-1:0] b_mem [N];

    logic [1:0]    pick;
    logic          sel_valid;
    logic [DW-1:0] sel_a;
    logic [DW-1:0] sel_b;
    logic          beat_xfer;
    logic          out_load;
    logic [PW-1:0] product;

    rr_arbiter2 u_arb (
        .req    (req),
        .rr_ptr (rr_ptr),
        .pick   (pick)
    );

    // out_id doubles as the granted requester index for the whole job.
    assign sel_valid = in_valid[out_id];
    assign sel_a     = out_id ? in_a1 : in_a0;
    assign sel_b     = out_id ? in_b1 : in_b0;
    assign beat_xfer = out_valid && !fifo_full;
    assign out_load  = (!out_valid || beat_xfer) && !issued_all;
    assign product   = PW'(a_mem[k[IW-1:CW]]) * PW'(b_mem[k[CW-1:0]]);
    assign busy      = (state != IDLE);
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (state == LOAD && sel_valid) begin
            a_mem[cnt] <= sel_a;
            b_mem[cnt] <= sel_b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rr_ptr     <= 1'b0;
            grant      <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_id     <= 1'b0;
            out_last   <= 1'b0;
            done       <= 1'b0;
            cnt        <= '0;
            k          <= '0;
            issued_all <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        grant  <= pick;
                        out_id <= pick[1];
                        cnt    <= '0;
                        state  <= LOAD;
                    end
                end
                LOAD: begin
                    if (sel_valid) begin
                        cnt <= cnt + 1'b1;
                        if (cnt == CW'(N - 1)) begin
                            k          <= '0;
                            issued_all <= 1'b0;
                            state      <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (out_load) begin
                        out_valid <= 1'b1;
                        out_data  <= product;
                        out_last  <= (k == IW'(N * N - 1));
                        k         <= k + 1'b1;
                        if (k == IW'(N * N - 1)) begin
                            issued_all <= 1'b1;
                        end
                    end else if (beat_xfer) begin
                        // Only reachable once every product has been issued.
                        out_valid <= 1'b0;
                        if (out_last) begin
                            out_last <= 1'b0;
                            done     <= 1'b1;
                            state    <= DONE;
                        end
                    end
                end
                DONE: begin
                    done   <= 1'b0;
                    grant  <= '0;
                    rr_ptr <= ~out_id;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/outer_product_scheduler.md
Name: outer_product_scheduler

Overview:
- Single-clock controller that shares one 16x16 outer-product engine between two requesters.
- Arbitrates between the requesters round-robin and loads the granted requester's A and B vectors (16 nibbles each).
- Sequences the 256 products A[i]*B[j] one per cycle into a FIFO write port, honouring fifo_full backpressure.
- Each result beat is tagged with the requester id; end of job is signalled with out_last and a done pulse.

Parameters:
- N, 16, vector length; products per job = N*N.
- DW, 4, element width of A and B.
- PW, 8, product width (2*DW).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset; synchronous, active-high.
- req  in  2  per-requester job request, level; held until the matching grant bit is seen.
- grant  out  2  one-hot grant; held from LOAD entry through DONE.
- in_valid  in  2  per-requester load beat valid; sampled only for the granted requester.
- in_a0, in_b0  in  DW each  requester 0 A[k] and B[k] for load beat k.
- in_a1, in_b1  in  DW each  requester 1 A[k] and B[k] for load beat k.
- fifo_full  in  1  downstream FIFO full.
- out_valid  out  1  result beat present; transfers when out_valid && !fifo_full.
- out_data  out  PW  product A[i]*B[j].
- out_id  out  1  requester id of the current job.
- out_last  out  1  high on the beat with i=j=N-1.
- busy  out  1  high in any state other than IDLE.
- done  out  1  single-cycle pulse in DONE.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE, rr_ptr=0.
  - grant=0, out_valid=0, out_data=0, out_id=0, out_last=0, busy=0, done=0.
  - Beat and index counters=0.
  - A/B storage need not be cleared.
  - Reset mid-job abandons the job immediately. No partial done is signalled.
- States: IDLE, LOAD, CALC, DONE.
- IDLE:
  - If any req bit is high, pick g. When both are high, g=rr_ptr; otherwise g is the single requester.
  - Next cycle: state=LOAD, grant[g]=1, out_id=g.
  - If no req is high, stay in IDLE.
- LOAD:
  - Each cycle with in_valid[g]=1, store A[cnt]<=in_a_g and B[cnt]<=in_b_g, then cnt++.
  - The non-granted requester's in_valid and data are ignored.
  - A gap (in_valid[g]=0) stalls the counter; there is no timeout.
  - The cycle after the 16th beat, state=CALC with k=0.
- CALC:
  - k runs 0..255, with i=k[7:4] and j=k[3:0].
  - The output register loads {A[i]*B[j] (unsigned, full PW), out_last=(k==255)} and sets out_valid=1. This happens when out_valid==0 or the current beat transfers.
  - The first beat appears 1 cycle after CALC entry.
  - Throughput is 1 beat/cycle while fifo_full=0.
  - While fifo_full=1 and out_valid=1: out_data, out_last and k are frozen, and out_valid stays 1.
  - When the last beat (out_last=1) transfers, out_valid goes to 0 next cycle and state=DONE.
  - No beat is dropped or duplicated; exactly 256 transfers occur per job.
- DONE:
  - For one cycle: done=1, grant still held.
  - Next cycle: grant=0, rr_ptr=~g, state=IDLE.
  - A new grant appears no earlier than 2 cycles after done.
- Arithmetic: unsigned DW x DW -> PW, no truncation. The maximum is 15*15=225.
- Simultaneous events:
  - req changing during LOAD/CALC has no effect on the active job.
  - A req dropped before grant is never granted.
  - fifo_full asserting in the same cycle as the last beat blocks that beat, and DONE waits.

Decomposition:
- Shared package (the team's common package):
  - state enum {IDLE, LOAD, CALC, DONE}.
  - Constants N, DW, PW.
  - Derived widths: $clog2(N) for the beat counter, $clog2(N*N) for the product index.
- One sub-module: rr_arbiter2, a 2-input round-robin pick.
  - Inputs: req[1:0], rr_ptr.
  - Output: one-hot pick.
  - Combinational; the pointer register stays in the parent.
- Everything else is in the parent: A/B storage, counters, output register.

Test Plan:
- Single job, no backpressure: req=01, A[k]=k, B[k]=15-k, fifo_full=0.
  - grant=01 one cycle after req, then 16 load beats.
  - 256 beats; beat 0 = 0*15 = 0, beat 17 (i=1, j=1) = 14, beat 255 = 15*0 = 0.
  - out_last only on beat 255, out_id=0, done 1 cycle after the last transfer.
- Contention: req=11 after reset.
  - Requester 0 is served first; after its done, requester 1 is granted (out_id=1).
  - With req held at 11, a third job goes to requester 0.
- Backpressure: A=B=all 15, fifo_full toggles 1 every other cycle plus a 20-cycle burst at k=100.
  - Exactly 256 transfers, all 225.
  - out_data stable while blocked; fifo_full blocking the out_last beat delays done.
- Load gaps and a foreign requester: granted requester 1 inserts in_valid gaps while requester 0 drives in_valid=1 with in_a0=in_b0=7 throughout.
  - Products use only requester 1 data.
  - CALC begins only after 16 valid beats from requester 1.
- Reset mid-CALC: assert rst at k=50.
  - Next cycle all outputs are 0 and state=IDLE; no done pulse.
  - A subsequent req=10 is granted to requester 1 (rr_ptr=0 after reset, only requester 1 requesting).
  - That job completes with 256 correct beats.
